audio_sample_feeder: RTL
========================

# audio_sample_feeder

Downstream of the sine-wave generator, upstream of `Audio_Controller`. Accepts raw signed samples and applies a per-sample attack/sustain/release envelope gated by the key-held level. It buffers scaled 32-bit samples in a small FIFO and issues `write_audio_out` only when the codec path reports `audio_out_allowed`. It replaces the hard on/off `Enable` gating with click-free note start and stop.

## Interface
- `SAMPLE_W`, 16: signed input sample width.
- `ENV_W`, 8: envelope level width; `ENV_MAX = 2**ENV_W-1`.
- `ATTACK_STEP`, 16: level increment per accepted sample in ATTACK.
- `RELEASE_STEP`, 8: level decrement per accepted sample in RELEASE.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `note_on`  in  1  level; high while a key/switch note is held.
- `sample_in`  in  SAMPLE_W  signed generator sample.
- `sample_valid`  in  1  one-cycle strobe marking a new `sample_in`.
- `sample_ready`  out  1  feeder can accept a sample this cycle.
- `audio_out_allowed`  in  1  controller has FIFO space.
- `left_channel_audio_out`  out  32  scaled sample (FIFO head).
- `right_channel_audio_out`  out  32  identical to left.
- `write_audio_out`  out  1  controller write strobe.
- `env_level`  out  ENV_W  current envelope level.
- `busy`  out  1  envelope nonzero, pipeline full, or FIFO non-empty.

## Operation
- Accept = `sample_valid && sample_ready`. When `sample_valid` arrives with `sample_ready` low, the sample is dropped and nothing else changes.
- Envelope FSM states and transitions. Transitions are evaluated every cycle; level changes only on accept.
  - IDLE: level 0. `note_on`=1 → ATTACK.
  - ATTACK: on accept, level += ATTACK_STEP, saturating at ENV_MAX. Reaching ENV_MAX → SUSTAIN. `note_on`=0 → RELEASE, which takes priority over the saturation transition in the same cycle.
  - SUSTAIN: level holds at ENV_MAX. `note_on`=0 → RELEASE.
  - RELEASE: on accept, level -= RELEASE_STEP, saturating at 0. Reaching 0 → IDLE. `note_on`=1 → ATTACK, continuing from the current level (retrigger, no jump to 0).
- Scaling: product = `sample_in` (signed) × level (unsigned, zero-extended). The level used is the value *before* that accept's update. The result is sign-extended and shifted left by 32−SAMPLE_W−ENV_W (8 at defaults) to form a 32-bit word.
- A sample accepted in IDLE is scaled by 0 and still enqueued, so the codec keeps receiving silence.
- `sample_ready` = (FIFO count + pipeline-register occupancy) < FIFO_DEPTH.
- Pop = FIFO non-empty && `audio_out_allowed`. `write_audio_out` = pop (combinational). Left/right outputs always show the FIFO head, and are 0 when empty.
- There is no bypass: a sample pushed in a cycle cannot be popped in the same cycle.
- Push and pop in the same cycle are both honoured; count is unchanged.

## Timing
- Reset values: all outputs 0, FSM IDLE, FIFO empty, pipeline register empty.
  - `sample_ready` is 1 one cycle after `resetn` deasserts.
- Reset asserted mid-operation clears all state immediately. In-flight and buffered samples are discarded.
- Latency from accept to the sample appearing at the FIFO head is 2 cycles:
  - cycle N: accept;
  - N+1: product registered;
  - N+2: at head, `write_audio_out` possible if allowed.
- Throughput is 1 sample/cycle while not full.
- `env_level` reflects an update on the cycle after the accept.

## Configuration
- `FEEDER_DROP_COUNT_EN` defined: adds output port `drop_count` [15:0]. It increments on every `sample_valid` received while `sample_ready` is low, saturates at 16'hFFFF, and resets to 0.
- Not defined: port and counter are absent; drops are silent.

## Structure
- Package `audio_feeder_pkg`:
  - envelope state enum (IDLE, ATTACK, SUSTAIN, RELEASE);
  - `ENV_MAX`;
  - the output shift constant.
- Sub-module `sample_fifo` (synchronous, show-ahead, parameterised width/depth, count output).
- Envelope FSM, multiplier stage and handshake logic live in the top module.

## Test plan
- Reset, then `note_on`=0 with constant valid `sample_in`=16'h4000 → every enqueued word is 0. `env_level`=0, FSM IDLE.
- `note_on` rises; 16 accepted samples of 16'h4000 → `env_level` reaches 255 on the 16th, FSM SUSTAIN, words thereafter 32'h3FC00000. With `sample_in`=16'hC000 → 32'hC0400000.
- `note_on` falls in SUSTAIN; 32 accepts → level goes 247, 239, …, 7, then 0, FSM IDLE, `busy` low once the FIFO drains.
- Release to level 127, then `note_on` rises → ATTACK continues 143, 159, … with no reset to 0.
- `audio_out_allowed`=0 with `sample_valid` held high → exactly 4 samples accepted, then `sample_ready`=0. With the macro defined, `drop_count` increments per further strobe. Raising allowed gives 4 consecutive `write_audio_out` pulses in order.
- Assert `resetn`=0 with 3 FIFO entries and FSM ATTACK → next cycle FIFO empty, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/audio_sample_feeder_pkg.sv
// Shared types and constants for the audio sample feeder: envelope states,
// default widths, envelope ceiling and the output alignment shift.
package audio_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_ENV_W    = 8;

  function automatic int env_max(input int env_w);
    return (2 ** env_w) - 1;
  endfunction

  // Left shift that places a SAMPLE_W x ENV_W product at the top of a 32-bit word.
  function automatic int out_shift(input int sample_w, input int env_w);
    return 32 - sample_w - env_w;
  endfunction

  localparam int ENV_MAX   = env_max(DEF_ENV_W);
  localparam int OUT_SHIFT = out_shift(DEF_SAMPLE_W, DEF_ENV_W);

endpackage

// File: rtl/audio_sample_feeder_if.sv
// Sample-in handshake and codec write path of the audio sample feeder.
// master = generator/controller side, slave = feeder.
interface audio_sample_feeder_if #(
  parameter int SAMPLE_W = 16
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;
  logic                       audio_out_allowed;
  logic [31:0]                left_channel_audio_out;
  logic [31:0]                right_channel_audio_out;
  logic                       write_audio_out;

  modport master (
    output sample_in, sample_valid, audio_out_allowed,
    input  sample_ready, left_channel_audio_out, right_channel_audio_out,
           write_audio_out
  );

  modport slave (
    input  sample_in, sample_valid, audio_out_allowed,
    output sample_ready, left_channel_audio_out, right_channel_audio_out,
           write_audio_out
  );
endinterface

// File: rtl/audio_sample_feeder_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry
// (zero when empty); push and pop in one cycle are both honoured.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; count gates every read, so
  // stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/audio_sample_feeder.sv
// Audio sample feeder: attack/sustain/release envelope, one-stage scaling
// multiplier and output FIFO in front of the codec controller.
// Optional FEEDER_DROP_COUNT_EN adds a saturating dropped-sample counter.
module audio_sample_feeder
  import audio_feeder_pkg::*;
#(
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int ENV_W        = DEF_ENV_W,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 note_on,
  audio_sample_feeder_if.slave bus,
  output logic [ENV_W-1:0]     env_level,
  output logic                 busy
`ifdef FEEDER_DROP_COUNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);
  localparam int LVL_MAX_I = env_max(ENV_W);
  localparam int SHIFT     = out_shift(SAMPLE_W, ENV_W);
  localparam int P_W       = SAMPLE_W + ENV_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ENV_W-1:0] LVL_MAX = ENV_W'(LVL_MAX_I);

  env_state_t       state;
  logic [ENV_W-1:0] level;
  logic [ENV_W-1:0] level_next;
  logic [ENV_W-1:0] lvl_up;
  logic [ENV_W-1:0] lvl_dn;
  int               up_sum;
  int               dn_diff;

  logic             ready_q;
  logic             accept;
  logic             pipe_valid;
  logic [31:0]      pipe_data;
  logic [31:0]      scaled;
  logic signed [P_W-1:0] smp_ext;
  logic signed [P_W-1:0] lvl_ext;
  logic signed [P_W-1:0] product;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] occ_next;
  logic [31:0]      fifo_head;
  logic             fifo_empty;
  logic             pop;

  assign accept     = bus.sample_valid && ready_q;
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && bus.audio_out_allowed;

  // Saturating level arithmetic done in int to avoid wrap at the ends.
  always_comb begin
    up_sum     = int'(level) + ATTACK_STEP;
    dn_diff    = int'(level) - RELEASE_STEP;
    lvl_up     = (up_sum >= LVL_MAX_I) ? LVL_MAX : ENV_W'(up_sum);
    lvl_dn     = (dn_diff <= 0) ? '0 : ENV_W'(dn_diff);
    level_next = level;
    case (state)
      ST_IDLE:    level_next = '0;
      ST_ATTACK:  if (accept) level_next = lvl_up;
      ST_SUSTAIN: level_next = LVL_MAX;
      ST_RELEASE: if (accept) level_next = lvl_dn;
      default:    level_next = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      level <= '0;
    end else begin
      level <= level_next;
      case (state)
        ST_IDLE:    if (note_on) state <= ST_ATTACK;
        ST_ATTACK:  if (!note_on)                   state <= ST_RELEASE;
                    else if (level_next == LVL_MAX) state <= ST_SUSTAIN;
        ST_SUSTAIN: if (!note_on) state <= ST_RELEASE;
        ST_RELEASE: if (note_on)                    state <= ST_ATTACK;
                    else if (level_next == '0)      state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Scaling uses the level held before this accept's update.
  always_comb begin
    smp_ext = P_W'(bus.sample_in);
    lvl_ext = P_W'({1'b0, level});
    product = smp_ext * lvl_ext;
    scaled  = {product, {SHIFT{1'b0}}};
  end

  // The pipeline register always drains into the FIFO next cycle; the
  // ready rule below guarantees the FIFO has room for it.
  assign count_next = fifo_count + CNT_W'(pipe_valid) - CNT_W'(pop);
  assign occ_next   = count_next + CNT_W'(accept);

  // NOTE: ready is registered from next-cycle occupancy so it matches the
  // combinational rule every cycle yet still reads 0 throughout reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) pipe_data <= scaled;
      ready_q    <= (occ_next < CNT_W'(FIFO_DEPTH));
    end
  end

  sample_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .push      (pipe_valid),
    .push_data (pipe_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.sample_ready            = ready_q;
  assign bus.write_audio_out         = pop;
  assign bus.left_channel_audio_out  = fifo_head;
  assign bus.right_channel_audio_out = fifo_head;
  assign env_level                   = level;
  assign busy = (level != '0) || pipe_valid || !fifo_empty;

`ifdef FEEDER_DROP_COUNT_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (bus.sample_valid && !ready_q && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
